// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Each digit slot lasts REFRESH_DIV cycles. The first BLANK_CYCLES of a slot
// keep every anode off so the previous digit cannot ghost into the next one.
// The codes and the blink mask are copied into shadow registers once per full
// scan, at the 7->0 wrap, so a scan never shows a mix of old and new values.
// A blink phase toggles every BLINK_SCANS completed scans.
// Code format: bit5 = blank, bits4:1 = character, bit0 = decimal point.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_SCANS  = 125
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  input  logic [7:0] blink,
  output logic [7:0] an,
  output logic [7:0] seg
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [SW-1:0] scan_cnt;
  logic          phase;
  logic [5:0]    code_sh [8];
  logic [7:0]    blink_sh;

  logic          tick;
  logic          wrap;
  logic [5:0]    code_sel;
  logic          dark;
  logic          in_blank;
  logic [7:0]    an_next;
  logic [7:0]    seg_next;

  assign tick     = (cnt == CW'(REFRESH_DIV - 1));
  assign wrap     = tick && (idx == 3'd7);
  assign in_blank = ({1'b0, cnt} < (CW + 1)'(BLANK_CYCLES));

  // Active-high gfedcba pattern for each 4-bit character.
  function automatic logic [6:0] char_pattern(input logic [3:0] ch);
    logic [6:0] p;
    case (ch)
      4'h0:    p = 7'h3F;
      4'h1:    p = 7'h06;
      4'h2:    p = 7'h5B;
      4'h3:    p = 7'h4F;
      4'h4:    p = 7'h66;
      4'h5:    p = 7'h6D;
      4'h6:    p = 7'h7D;
      4'h7:    p = 7'h07;
      4'h8:    p = 7'h7F;
      4'h9:    p = 7'h6F;
      4'hA:    p = 7'h73;
      4'hB:    p = 7'h7C;
      4'hC:    p = 7'h58;
      4'hD:    p = 7'h6D;
      4'hE:    p = 7'h79;
      default: p = 7'h3E;
    endcase
    return p;
  endfunction

  // Refresh prescaler, digit index, scan counter and blink phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= 3'd0;
      scan_cnt <= '0;
      phase    <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= idx + 3'd1;
      end
      if (wrap) begin
        if (scan_cnt == SW'(BLINK_SCANS - 1)) begin
          scan_cnt <= '0;
          phase    <= ~phase;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end
    end
  end

  // Shadow copies of the inputs, refreshed only at the start of a new scan.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        code_sh[i] <= 6'b111111;
      end
      blink_sh <= 8'h00;
    end else if (wrap) begin
      code_sh[0] <= d1;
      code_sh[1] <= d2;
      code_sh[2] <= d3;
      code_sh[3] <= d4;
      code_sh[4] <= d5;
      code_sh[5] <= d6;
      code_sh[6] <= d7;
      code_sh[7] <= d8;
      blink_sh   <= blink;
    end
  end

  // Decode the selected digit; dark during the blanking window or when off.
  always_comb begin
    an_next  = 8'hFF;
    seg_next = 8'hFF;
    code_sel = code_sh[idx];
    dark     = code_sel[5] | (phase & blink_sh[idx]);
    if (!in_blank && !dark) begin
      an_next  = ~(8'h80 >> idx);
      seg_next = ~{code_sel[0], char_pattern(code_sel[4:1])};
    end
  end

  // Registered pins, forced dark by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with small parameters so scans are short.
// The reference model derives slot, digit and scan number from the count of
// clock edges since reset release, and the blink phase from the scan number.
module tb_seg7_scan_driver;

  localparam int RD   = 4;
  localparam int BC   = 1;
  localparam int BS   = 2;
  localparam int SCAN = 8 * RD;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] d [8];
  logic [7:0] blink;
  logic [7:0] an;
  logic [7:0] seg;

  int errors = 0;
  int checks = 0;
  int e      = 0;

  logic [15:0] exp_q [$];
  logic [5:0]  m_code [8];
  logic [7:0]  m_blink;
  logic [6:0]  char_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h73, 7'h7C, 7'h58, 7'h6D, 7'h79, 7'h3E};

  seg7_scan_driver #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .BLINK_SCANS (BS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .d1   (d[0]),
    .d2   (d[1]),
    .d3   (d[2]),
    .d4   (d[3]),
    .d5   (d[4]),
    .d6   (d[5]),
    .d7   (d[6]),
    .d8   (d[7]),
    .blink(blink),
    .an   (an),
    .seg  (seg)
  );

  // Clock
  always #5 clock = ~clock;

  function automatic logic [5:0] code(input int ch, input bit dp);
    logic [3:0] c4;
    c4 = 4'(ch);
    return {1'b0, c4, dp};
  endfunction

  // Expected {an, seg} for the display state reached after n edges.
  function automatic logic [15:0] model_out(input int n);
    int         c;
    int         i;
    int         s;
    bit         ph;
    logic [5:0] cd;
    c  = n % RD;
    i  = (n / RD) % 8;
    s  = n / SCAN;
    ph = ((s / BS) % 2) == 1;
    cd = m_code[i];
    if (c < BC) return 16'hFFFF;
    if (cd[5] || (ph && m_blink[i])) return 16'hFFFF;
    return {~(8'h80 >> i), ~{cd[0], char_tab[cd[4:1]]}};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_code[i] = 6'b111111;
    m_blink = 8'h00;
    e = 0;
    exp_q.delete();
  endtask

  // One clock: predict, capture shadows at the scan boundary, then compare.
  task automatic step();
    logic [15:0] exp_v;
    @(posedge clock);
    e++;
    exp_q.push_back(model_out(e - 1));
    if (e % SCAN == 0) begin
      for (int i = 0; i < 8; i++) m_code[i] = d[i];
      m_blink = blink;
    end
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    assert ({an, seg} === exp_v) else begin
      errors++;
      $error("FAIL pins e=%0d got an=%h seg=%h want an=%h seg=%h", e, an, seg, exp_v[15:8], exp_v[7:0]);
    end
    checks++;
    assert ($onehot0(~an)) else begin
      errors++;
      $error("FAIL onehot e=%0d got an=%h want at most one low", e, an);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to(input int pos);
    while (e % SCAN != pos) step();
  endtask

  // Reset pulse asserted away from the clock edge; pins must go dark at once.
  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    assert ({an, seg} === 16'hFFFF) else begin
      errors++;
      $error("FAIL reset_async got an=%h seg=%h want an=ff seg=ff", an, seg);
    end
    repeat (cycles) @(posedge clock);
    #1;
    checks++;
    assert ({an, seg} === 16'hFFFF) else begin
      errors++;
      $error("FAIL reset_hold got an=%h seg=%h want an=ff seg=ff", an, seg);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) d[i] = 6'b111111;
    blink = 8'h00;
    model_reset();

    // Reset, then a first scan that must stay dark.
    do_reset(3);
    run(SCAN);

    // Only d1 shows '1'; everything else blanked.
    d[0] = code(1, 1'b0);
    for (int i = 1; i < 8; i++) d[i] = 6'b100000;
    run(3 * SCAN);

    // 'P' with decimal point on d4, 'U' on d8.
    d[3] = code(10, 1'b1);
    d[7] = code(15, 1'b0);
    run(2 * SCAN);

    // d2 changes mid-scan; the new value must wait for the next wrap.
    d[1] = code(2, 1'b0);
    run(1);
    run_to(0);
    run_to(17);
    d[1] = code(9, 1'b0);
    run(2 * SCAN);

    // Blink on d1 showing '8'.
    blink = 8'h01;
    d[0]  = code(8, 1'b0);
    run(7 * SCAN);

    // Random codes and masks changed at random points in the scan.
    repeat (30) begin
      for (int i = 0; i < 8; i++) d[i] = 6'($urandom_range(0, 63));
      blink = 8'($urandom);
      run($urandom_range(1, 48));
    end

    // Reset in the middle of slot 5 (cnt=2), then a dark restart.
    run_to(22);
    do_reset(1);
    run(2 * SCAN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
